ram_arbiter: RTL

- Shares the single data RAM port between two requesters: requester 0 is the NBBPU data port, requester 1 is an auxiliary master (program loader / debug port).
- Sits between nbbpu/aux master and ram; drives the RAM select, write enable, address and write data, and returns read data with a valid strobe.
- Round-robin arbitration with a bounded burst length, so neither requester starves the other.

---
 rtl/ram_arbiter_pkg.sv | 19 +
 rtl/ram_arbiter_tracker.sv | 44 ++++
 rtl/ram_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the RAM port arbiter: requester ids, default
// burst limit and the default status address watched by the halt logic.
package ram_arbiter_pkg;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_AUX = 1'b1
  } req_id_e;

  localparam int          DEFAULT_MAX_BURST    = 4;
  localparam logic [15:0] DEFAULT_HALT_ADDRESS = 16'hFFF0;
  localparam int          BURST_WIDTH          = 4;

  // Id of the requester that is not 'id'.
  function automatic logic other_id(input logic id);
    return ~id;
  endfunction

endpackage

// File: rtl/ram_arbiter_tracker.sv
// rr_burst_tracker: remembers who was granted last (the priority pointer)
// and how many consecutive grants that requester has received, saturating
// at MAX_BURST. burst_full tells the arbiter to hand over on contention.
module rr_burst_tracker
  import ram_arbiter_pkg::*;
#(
  parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
  input  logic clock,
  input  logic reset,
  input  logic grant_valid,
  input  logic grant_id,
  output logic priority_id,
  output logic burst_full
);

  localparam logic [BURST_WIDTH-1:0] MAX_COUNT = BURST_WIDTH'(MAX_BURST);

  logic                   ptr_r;
  logic [BURST_WIDTH-1:0] burst_count_r;

  // Pointer follows the granted id; the count tracks the current run of grants.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_r         <= REQ_CPU;
      burst_count_r <= {BURST_WIDTH{1'b0}};
    end else if (grant_valid) begin
      if (grant_id == ptr_r) begin
        if (burst_count_r != MAX_COUNT) begin
          burst_count_r <= burst_count_r + {{(BURST_WIDTH-1){1'b0}}, 1'b1};
        end
      end else begin
        ptr_r         <= grant_id;
        burst_count_r <= {{(BURST_WIDTH-1){1'b0}}, 1'b1};
      end
    end else begin
      burst_count_r <= {BURST_WIDTH{1'b0}};
    end
  end

  assign priority_id = ptr_r;
  assign burst_full  = (burst_count_r == MAX_COUNT);

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one RAM port between the NBBPU data port (requester 0)
// and an auxiliary master (requester 1) with round-robin, burst-limited
// arbitration. Grants are combinational; read data returns one cycle later
// with a per-requester valid strobe.
// Optional halt detection is enabled by defining RAM_ARBITER_HALT_EN.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    DATA_WIDTH   = 16,
  parameter int                    MAX_BURST    = DEFAULT_MAX_BURST,
  parameter logic [ADDR_WIDTH-1:0] HALT_ADDRESS = ADDR_WIDTH'(DEFAULT_HALT_ADDRESS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ram_select,
  output logic                  ram_write_enable,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_write_data,
  input  logic [DATA_WIDTH-1:0] ram_read_data,
  output logic                  halted,
  output logic [DATA_WIDTH-1:0] halt_code
);

  logic                  req0_eff_s;
  logic                  grant_valid_s;
  logic                  grant_id_s;
  logic                  priority_id_s;
  logic                  burst_full_s;
  logic                  sel_we_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [DATA_WIDTH-1:0] sel_wdata_s;
  logic [ADDR_WIDTH-1:0] addr_hold_r;
  logic [DATA_WIDTH-1:0] wdata_hold_r;
  logic                  rvalid0_r;
  logic                  rvalid1_r;
  logic                  halted_s;
  logic [DATA_WIDTH-1:0] halt_code_s;

  rr_burst_tracker #(
    .MAX_BURST (MAX_BURST)
  ) u_tracker (
    .clock       (clock),
    .reset       (reset),
    .grant_valid (grant_valid_s),
    .grant_id    (grant_id_s),
    .priority_id (priority_id_s),
    .burst_full  (burst_full_s)
  );

  // Pick at most one winner; on contention the pointer wins unless its burst is used up.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_id_s    = REQ_CPU;
    if (reset) begin
      grant_valid_s = 1'b0;
      grant_id_s    = REQ_CPU;
    end else if (req0_eff_s && req1) begin
      grant_valid_s = 1'b1;
      grant_id_s    = burst_full_s ? other_id(priority_id_s) : priority_id_s;
    end else if (req0_eff_s) begin
      grant_valid_s = 1'b1;
      grant_id_s    = REQ_CPU;
    end else if (req1) begin
      grant_valid_s = 1'b1;
      grant_id_s    = REQ_AUX;
    end else begin
      grant_valid_s = 1'b0;
      grant_id_s    = REQ_CPU;
    end
  end

  // Select the granted requester's access fields.
  always_comb begin
    sel_we_s    = 1'b0;
    sel_addr_s  = addr0;
    sel_wdata_s = wdata0;
    case (grant_id_s)
      REQ_CPU: begin
        sel_we_s    = we0;
        sel_addr_s  = addr0;
        sel_wdata_s = wdata0;
      end
      REQ_AUX: begin
        sel_we_s    = we1;
        sel_addr_s  = addr1;
        sel_wdata_s = wdata1;
      end
      default: begin
        sel_we_s    = 1'b0;
        sel_addr_s  = addr0;
        sel_wdata_s = wdata0;
      end
    endcase
  end

  // Remember the last driven address/data so idle cycles do not toggle the RAM bus.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_hold_r  <= {ADDR_WIDTH{1'b0}};
      wdata_hold_r <= {DATA_WIDTH{1'b0}};
    end else if (grant_valid_s) begin
      addr_hold_r  <= sel_addr_s;
      wdata_hold_r <= sel_wdata_s;
    end
  end

  // Read-valid strobes fire the cycle after a granted read and are dropped by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rvalid0_r <= 1'b0;
      rvalid1_r <= 1'b0;
    end else begin
      rvalid0_r <= gnt0 & ~we0;
      rvalid1_r <= gnt1 & ~we1;
    end
  end

`ifdef RAM_ARBITER_HALT_EN
  logic                  halted_r;
  logic [DATA_WIDTH-1:0] halt_code_r;

  // A CPU write to the status address latches the halt code and locks the CPU out.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      halted_r    <= 1'b0;
      halt_code_r <= {DATA_WIDTH{1'b0}};
    end else if (gnt0 && we0 && (addr0 == HALT_ADDRESS)) begin
      halted_r    <= 1'b1;
      halt_code_r <= wdata0;
    end
  end

  assign halted_s    = halted_r;
  assign halt_code_s = halt_code_r;
`else
  assign halted_s    = 1'b0;
  assign halt_code_s = {DATA_WIDTH{1'b0}};
`endif

  assign req0_eff_s       = req0 & ~halted_s;
  assign gnt0             = grant_valid_s & (grant_id_s == REQ_CPU);
  assign gnt1             = grant_valid_s & (grant_id_s == REQ_AUX);
  assign ram_select       = grant_valid_s;
  assign ram_write_enable = grant_valid_s & sel_we_s;
  assign ram_address      = grant_valid_s ? sel_addr_s : addr_hold_r;
  assign ram_write_data   = grant_valid_s ? sel_wdata_s : wdata_hold_r;
  assign rvalid0          = rvalid0_r;
  assign rvalid1          = rvalid1_r;
  assign rdata            = ram_read_data;
  assign halted           = halted_s;
  assign halt_code        = halt_code_s;

endmodule
